// File: rtl/hwag_spi_tx_data_frame.sv
// hwag_spi_tx_data_frame
//   Transmit-side framer for the HWAG SPI slave. After every request frame it
//   builds the 7-byte response [STAT]:[ADDR]:[DATA32]:[CRC8]. The response is
//   presented byte by byte on spi_slave's bus_in during the next SPI
//   transaction, which gives one transaction of latency.
//
// Ports
//   clk, nrst      system clock, asynchronous active-low reset
//   spi_ss         slave select (active low), already synchronised to clk
//   frame_done     1-clk pulse when a request frame ends; qualifies
//                  frame_crc_ok, frame_cmd and frame_addr
//   spi_tx         1-clk pulse when spi_slave latches tx_byte into its shifter
//   rd_strb/rd_addr  read strobe and address to the register mux
//   rd_data        register data, valid the cycle after rd_strb
//   tx_byte        byte presented to spi_slave bus_in
//   frame_armed    a built response waits for the next transaction
module hwag_spi_tx_data_frame #(
  parameter logic [7:0] RD_CMD   = 8'h01,
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        spi_ss,
  input  logic        frame_done,
  input  logic        frame_crc_ok,
  input  logic [7:0]  frame_cmd,
  input  logic [7:0]  frame_addr,
  input  logic        spi_tx,
  output logic        rd_strb,
  output logic [7:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_byte,
  output logic        frame_armed
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, CRC, READY, SEND} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_ss_d;
  logic        r_crc_ok;
  logic [7:0]  r_cmd, r_addr, r_stat, r_crc;
  logic [31:0] r_data;
  logic [2:0]  r_idx;
  logic        w_ss_fall, w_ss_rise, w_fd_take;
  logic [7:0]  w_sel_byte;

  // One CRC-8 byte step (MSB first, init/xorout handled by the caller).
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    return r;
  endfunction

  assign w_ss_fall = r_ss_d & ~spi_ss;
  assign w_ss_rise = ~r_ss_d & spi_ss;
  // While the response goes out, a frame_done is honoured only together with
  // the ss rise that ends the transaction. A pulse with ss still low is
  // treated as a glitch.
  assign w_fd_take = frame_done & ((r_state != SEND) | w_ss_rise);

  // The byte index selects the CRC input while building and the outgoing
  // byte while sending. Index 7 means the frame is exhausted.
  always_comb begin
    w_sel_byte = 8'h00;
    case (r_idx)
      3'd0: w_sel_byte = r_stat;
      3'd1: w_sel_byte = r_addr;
      3'd2: w_sel_byte = r_data[31:24];
      3'd3: w_sel_byte = r_data[23:16];
      3'd4: w_sel_byte = r_data[15:8];
      3'd5: w_sel_byte = r_data[7:0];
      3'd6: w_sel_byte = r_crc;
      default: w_sel_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_fd_take) w_state_nxt = FETCH;
    else begin
      case (r_state)
        FETCH:   w_state_nxt = CAPTURE;
        CAPTURE: w_state_nxt = CRC;
        CRC:     if (r_idx == 3'd5) w_state_nxt = READY;
        READY:   if (w_ss_fall) w_state_nxt = SEND;
        SEND:    if (w_ss_rise) w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ss_d   <= 1'b1;
      r_crc_ok <= 1'b0;
      r_cmd    <= 8'h00;
      r_addr   <= 8'h00;
      r_stat   <= 8'h00;
      r_data   <= 32'h0;
      r_crc    <= 8'h00;
      r_idx    <= 3'd0;
    end else begin
      r_ss_d <= spi_ss;
      if (w_fd_take) begin
        r_crc_ok <= frame_crc_ok;
        r_cmd    <= frame_cmd;
        r_addr   <= frame_addr;
        r_idx    <= 3'd0;
      end else begin
        case (r_state)
          CAPTURE: begin
            if (!r_crc_ok) begin
              r_stat <= 8'hFF;
              r_data <= 32'h0;
            end else if (r_cmd == RD_CMD) begin
              r_stat <= r_cmd;
              r_data <= rd_data;
            end else begin
              r_stat <= r_cmd | 8'h80;
              r_data <= 32'h0;
            end
            r_crc <= 8'h00;
            r_idx <= 3'd0;
          end
          CRC: begin
            r_crc <= crc8_byte(r_crc, w_sel_byte);
            r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
          end
          SEND: begin
            if (w_ss_rise)                   r_idx <= 3'd0;
            else if (spi_tx && r_idx != 3'd7) r_idx <= r_idx + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_strb     = (r_state == FETCH);
  assign rd_addr     = r_addr;
  assign frame_armed = (r_state == READY) | (r_state == SEND);

  // STAT is driven in the same cycle as the arming ss fall, so spi_slave
  // can load it before the first SCK. Outside of an armed transaction the
  // bus carries zeros.
  always_comb begin
    tx_byte = 8'h00;
    if (r_state == SEND)                                    tx_byte = w_sel_byte;
    else if (r_state == READY && w_ss_fall && !frame_done) tx_byte = r_stat;
  end

endmodule

// File: tb/tb_hwag_spi_tx_data_frame.sv
module tb_hwag_spi_tx_data_frame;
  localparam logic [7:0] RD_CMD   = 8'h01;
  localparam logic [7:0] CRC_POLY = 8'h07;

  logic        clk = 1'b0, nrst = 1'b1, spi_ss = 1'b1, frame_done = 1'b0;
  logic        frame_crc_ok = 1'b0, spi_tx = 1'b0;
  logic [7:0]  frame_cmd = 8'h00, frame_addr = 8'h00;
  logic [31:0] rd_data = 32'h0;
  logic        rd_strb, frame_armed;
  logic [7:0]  rd_addr, tx_byte;

  hwag_spi_tx_data_frame #(.RD_CMD(RD_CMD), .CRC_POLY(CRC_POLY)) dut (
    .clk(clk), .nrst(nrst), .spi_ss(spi_ss), .frame_done(frame_done),
    .frame_crc_ok(frame_crc_ok), .frame_cmd(frame_cmd), .frame_addr(frame_addr),
    .spi_tx(spi_tx), .rd_strb(rd_strb), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_byte(tx_byte), .frame_armed(frame_armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ok;
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  exp_stat;
    logic [31:0] exp_data;
  } vec_t;

  vec_t             tbl[5];
  int               errors = 0, checks = 0;
  logic [6:0][7:0]  m_frame;
  bit               m_armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Bit-serial CRC-8 reference: MSB first, init 0, no reflection or xorout.
  function automatic logic [7:0] crc_model(input logic [8:0][7:0] b, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < n; k++)
      for (int j = 7; j >= 0; j--) begin
        fb = c[7] ^ b[k][j];
        c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      end
    return c;
  endfunction

  function automatic logic [6:0][7:0] frame_of(input logic [7:0] stat, input logic [7:0] addr,
                                               input logic [31:0] d);
    logic [6:0][7:0] f;
    logic [8:0][7:0] b;
    f[0] = stat; f[1] = addr;
    f[2] = d[31:24]; f[3] = d[23:16]; f[4] = d[15:8]; f[5] = d[7:0];
    b = '0;
    for (int k = 0; k < 6; k++) b[k] = f[k];
    f[6] = crc_model(b, 6);
    return f;
  endfunction

  function automatic logic [7:0] model_stat(input logic ok, input logic [7:0] cmd);
    if (!ok) return 8'hFF;
    return (cmd == RD_CMD) ? cmd : (cmd | 8'h80);
  endfunction

  function automatic logic [31:0] model_data(input logic ok, input logic [7:0] cmd,
                                             input logic [31:0] d);
    return (ok && cmd == RD_CMD) ? d : 32'h0;
  endfunction

  // Pulse frame_done (cycle N) and return in N+1 with the read strobe checked.
  task automatic start_req(input logic ok, input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [31:0] d);
    frame_crc_ok = ok; frame_cmd = cmd; frame_addr = addr; rd_data = d; frame_done = 1'b1;
    cyc();
    frame_done = 1'b0; frame_crc_ok = ~ok; frame_cmd = ~cmd; frame_addr = ~addr;
    chk("rd_strb@N+1", 32'(rd_strb), 32'd1);
    chk("rd_addr@N+1", 32'(rd_addr), 32'(addr));
  endtask

  // From N+1 run to N+9, checking the strobe drops and frame_armed timing.
  task automatic finish_build();
    cyc();
    chk("rd_strb@N+2", 32'(rd_strb), 32'd0);
    cyc();
    rd_data = ~rd_data;
    repeat (5) cyc();
    chk("armed@N+8", 32'(frame_armed), 32'd0);
    cyc();
    chk("armed@N+9", 32'(frame_armed), 32'd1);
  endtask

  task automatic do_req(input logic ok, input logic [7:0] cmd, input logic [7:0] addr,
                        input logic [31:0] d);
    start_req(ok, cmd, addr, d);
    finish_build();
    m_frame = frame_of(model_stat(ok, cmd), addr, model_data(ok, cmd, d));
    m_armed = 1'b1;
  endtask

  // One SPI transaction of nb bytes, checked against the model.
  task automatic run_txn(input int nb, input string tag);
    logic [7:0] exp;
    spi_ss = 1'b0;
    #1;
    chk($sformatf("%s first", tag), 32'(tx_byte), 32'(m_armed ? m_frame[0] : 8'h00));
    cyc();
    for (int i = 0; i < nb; i++) begin
      exp = (m_armed && i < 7) ? m_frame[i] : 8'h00;
      chk($sformatf("%s byte%0d", tag, i), 32'(tx_byte), 32'(exp));
      spi_tx = 1'b1; cyc(); spi_tx = 1'b0; cyc();
    end
    spi_ss = 1'b1;
    cyc();
    m_armed = 1'b0;
    chk($sformatf("%s armed_after", tag), 32'(frame_armed), 32'd0);
    chk($sformatf("%s tx_after", tag), 32'(tx_byte), 32'd0);
  endtask

  initial begin
    logic [8:0][7:0] asc;
    logic            ok;
    logic [7:0]      cmd, addr;
    logic [31:0]     d;
    int              r;

    tbl[0] = '{1'b1, 8'h01, 8'h01, 32'h00123456, 8'h01, 32'h00123456};
    tbl[1] = '{1'b0, 8'h01, 8'h05, 32'hDEADBEEF, 8'hFF, 32'h0};
    tbl[2] = '{1'b1, 8'h02, 8'h10, 32'h11111111, 8'h82, 32'h0};
    tbl[3] = '{1'b1, 8'h00, 8'hA5, 32'hCAFEF00D, 8'h80, 32'h0};
    tbl[4] = '{1'b1, 8'h01, 8'hFF, 32'hFFFFFFFF, 8'h01, 32'hFFFFFFFF};

    for (int k = 0; k < 9; k++) asc[k] = 8'h31 + 8'(k);
    chk("crc_check_123456789", 32'(crc_model(asc, 9)), 32'hF4);

    #1 nrst = 1'b0;
    #1;
    chk("rst tx_byte", 32'(tx_byte), 32'd0);
    chk("rst rd_strb", 32'(rd_strb), 32'd0);
    chk("rst rd_addr", 32'(rd_addr), 32'd0);
    chk("rst armed", 32'(frame_armed), 32'd0);
    repeat (3) cyc();
    nrst = 1'b1;
    cyc();

    // Table-driven frames, each read out with an extra 8th byte.
    for (int i = 0; i < 5; i++) begin
      start_req(tbl[i].ok, tbl[i].cmd, tbl[i].addr, tbl[i].data);
      finish_build();
      m_frame = frame_of(tbl[i].exp_stat, tbl[i].addr, tbl[i].exp_data);
      m_armed = 1'b1;
      run_txn(8, $sformatf("tbl%0d", i));
    end

    // Write ack aborted after 3 bytes; the next transaction carries zeros.
    do_req(1'b1, 8'h02, 8'h33, 32'h12345678);
    run_txn(3, "abort");
    run_txn(7, "after_abort");

    // ss falls mid-build: that transaction sends zeros, the frame survives.
    start_req(1'b1, 8'h01, 8'h44, 32'hA5A50F0F);
    repeat (4) cyc();
    spi_ss = 1'b0; spi_tx = 1'b1;
    #1 chk("midcrc tx@fall", 32'(tx_byte), 32'd0);
    cyc(); spi_tx = 1'b0;
    chk("midcrc tx@N+6", 32'(tx_byte), 32'd0);
    cyc(); cyc();
    chk("midcrc armed@N+8", 32'(frame_armed), 32'd0);
    cyc();
    chk("midcrc armed@N+9", 32'(frame_armed), 32'd1);
    chk("midcrc tx@N+9", 32'(tx_byte), 32'd0);
    spi_tx = 1'b1; cyc(); spi_tx = 1'b0;
    chk("midcrc tx_after_pulse", 32'(tx_byte), 32'd0);
    spi_ss = 1'b1; cyc(); cyc();
    chk("midcrc armed_held", 32'(frame_armed), 32'd1);
    m_frame = frame_of(8'h01, 8'h44, 32'hA5A50F0F); m_armed = 1'b1;
    run_txn(8, "midcrc_next");

    // A newer frame_done at N+4 discards the first build.
    start_req(1'b1, 8'h01, 8'h20, 32'h11223344);
    repeat (3) cyc();
    do_req(1'b1, 8'h01, 8'h21, 32'h55667788);
    run_txn(7, "supersede");

    // Async reset after two bytes of a transaction.
    do_req(1'b1, 8'h01, 8'h07, 32'hCAFEBABE);
    spi_ss = 1'b0; cyc();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rstsend byte%0d", i), 32'(tx_byte), 32'(m_frame[i]));
      spi_tx = 1'b1; cyc(); spi_tx = 1'b0; cyc();
    end
    nrst = 1'b0;
    #1;
    chk("rstsend tx", 32'(tx_byte), 32'd0);
    chk("rstsend armed", 32'(frame_armed), 32'd0);
    spi_ss = 1'b1; cyc();
    nrst = 1'b1; m_armed = 1'b0;
    cyc();
    run_txn(7, "after_rst");

    // Randomised requests and transactions against the frame model.
    for (int it = 0; it < 30; it++) begin
      r    = $urandom_range(0, 9);
      ok   = ($urandom_range(0, 3) != 0);
      cmd  = ($urandom_range(0, 1) == 1) ? RD_CMD : 8'($urandom);
      addr = 8'($urandom);
      d    = $urandom;
      if (r < 2) begin
        run_txn($urandom_range(1, 8), $sformatf("rnd%0d_idle", it));
      end else begin
        if (r == 9) begin
          start_req(~ok, 8'($urandom), 8'($urandom), $urandom);
          repeat (2) cyc();
        end else if (r == 8) begin
          do_req(~ok, 8'($urandom), 8'($urandom), $urandom);
        end
        do_req(ok, cmd, addr, d);
        run_txn($urandom_range(1, 8), $sformatf("rnd%0d", it));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
